// File: rtl/fsm_step_controller.sv
// fsm_step_controller: step sequencer and lockstep checker for paired one-hot/binary detector FSMs.
// Optional FSM_STEP_HALT_ON_ERR_EN: freeze in HALT on the first mismatch or illegal one-hot state.
module fsm_step_controller #(
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter int          RUN_DIV         = 4,
    parameter int          PATTERN_LEN     = 16,
    parameter logic [31:0] PATTERN         = 32'h0000B3F0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       w_sw,
    input  logic       step_btn,
    input  logic       run_sw,
    input  logic       z_a,
    input  logic       z_b,
    input  logic [4:0] onehot_state,
    output logic       w_out,
    output logic       step_en,
    output logic       busy,
    output logic       mismatch,
    output logic       illegal_onehot,
    output logic [7:0] step_count
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DW = $clog2(RUN_DIV);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
`ifdef FSM_STEP_HALT_ON_ERR_EN
        , HALT
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      w_sync_q, btn_sync_q, run_sync_q;
    logic            db_q, db_d, db_dly_q;
    logic [CW-1:0]   db_cnt_q, db_cnt_d;
    logic [4:0]      idx_q, idx_d;
    logic [DW-1:0]   div_q, div_d;
    logic            w_out_q, w_d, step_en_q, step_d, chk_q;
    logic            mismatch_q, mismatch_d, illegal_q, illegal_d;
    logic [7:0]      count_q, count_d;
    logic            req, run;

    assign run = run_sync_q[1];
    assign req = db_q & ~db_dly_q;

    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (btn_sync_q[1] != db_q) begin
            db_cnt_d = db_cnt_q + 1'b1;
            if (db_cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_d     = ~db_q;
                db_cnt_d = '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        div_d   = div_q;
        w_d     = w_out_q;
        step_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = RUN;
                    idx_d   = '0;
                    div_d   = '0;
                end else if (req) begin
                    step_d = 1'b1;
                    w_d    = w_sync_q[1];
                end
            end
            RUN: begin
                if (!run) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (div_q == DW'(RUN_DIV - 1)) begin
                    div_d   = '0;
                    step_d  = 1'b1;
                    w_d     = PATTERN[idx_q];
                    idx_d   = idx_q + 1'b1;
                    state_d = (idx_q == 5'(PATTERN_LEN - 1)) ? DONE : RUN;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DONE: state_d = run ? DONE : IDLE;
            default: ;
        endcase
`ifdef FSM_STEP_HALT_ON_ERR_EN
        if (mismatch_q | illegal_q) begin
            state_d = HALT;
            step_d  = 1'b0;
        end
`endif
    end

    // chk_q is the check strobe: the cycle after each step, when both FSMs show their new state.
    assign mismatch_d = mismatch_q | (chk_q & (z_a ^ z_b));
    assign illegal_d  = illegal_q | (chk_q & ($countones(onehot_state) != 1));
    assign count_d    = count_q + {7'd0, step_en_q & ~&count_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_sync_q   <= '0;
            btn_sync_q <= '0;
            run_sync_q <= '0;
            db_q       <= 1'b0;
            db_dly_q   <= 1'b0;
            db_cnt_q   <= '0;
            state_q    <= IDLE;
            idx_q      <= '0;
            div_q      <= '0;
            w_out_q    <= 1'b0;
            step_en_q  <= 1'b0;
            chk_q      <= 1'b0;
            mismatch_q <= 1'b0;
            illegal_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            w_sync_q   <= {w_sync_q[0], w_sw};
            btn_sync_q <= {btn_sync_q[0], step_btn};
            run_sync_q <= {run_sync_q[0], run_sw};
            db_q       <= db_d;
            db_dly_q   <= db_q;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            div_q      <= div_d;
            w_out_q    <= w_d;
            step_en_q  <= step_d;
            chk_q      <= step_en_q;
            mismatch_q <= mismatch_d;
            illegal_q  <= illegal_d;
            count_q    <= count_d;
        end
    end

    assign w_out          = w_out_q;
    assign step_en        = step_en_q;
    assign busy           = state_q == RUN;
    assign mismatch       = mismatch_q;
    assign illegal_onehot = illegal_q;
    assign step_count     = count_q;
endmodule

// File: tb/tb_fsm_step_controller.sv
// tb_fsm_step_controller: scoreboard bench for fsm_step_controller; expected w_out values are
// queued when steps are requested and popped by a monitor on every step_en pulse.
module tb_fsm_step_controller;
    logic       clk = 1'b0;
    logic       reset, w_sw, step_btn, run_sw, z_a, z_b;
    logic [4:0] onehot_state;
    logic       w_out, step_en, busy, mismatch, illegal_onehot;
    logic [7:0] step_count;

    int         checks = 0;
    int         fails = 0;
    logic       exp_q[$];
    logic       prev_en = 1'b0;
    logic       e;
    logic [15:0] seq = 16'b1011_0011_1111_0000;

    fsm_step_controller dut (
        .clk(clk), .reset(reset), .w_sw(w_sw), .step_btn(step_btn), .run_sw(run_sw),
        .z_a(z_a), .z_b(z_b), .onehot_state(onehot_state), .w_out(w_out),
        .step_en(step_en), .busy(busy), .mismatch(mismatch),
        .illegal_onehot(illegal_onehot), .step_count(step_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            prev_en = 1'b0;
        end else begin
            if (step_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_step: w_out=%b but no step was expected", w_out);
                end else begin
                    e = exp_q.pop_front();
                    if (w_out !== e) begin
                        fails++;
                        $display("FAIL step_w_out: got %b want %b", w_out, e);
                    end
                end
                checks++;
                if (prev_en) begin
                    fails++;
                    $display("FAIL step_en_consecutive: got 1 on back-to-back cycles want 0");
                end
            end
            prev_en = step_en;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_pulses(input int target, input int budget, input int gap, output int got);
        int last;
        last = -1;
        got = 0;
        for (int c = 0; c < budget && got < target; c++) begin
            @(negedge clk);
            if (step_en) begin
                if (gap != 0 && last >= 0) begin
                    checks++;
                    if (c - last != gap) begin
                        fails++;
                        $display("FAIL step_gap: got %0d want %0d", c - last, gap);
                    end
                end
                last = c;
                got++;
            end
        end
        checks++;
        if (got != target) begin
            fails++;
            $display("FAIL pulse_count: got %0d want %0d", got, target);
        end
    endtask

    task automatic do_reset;
        reset = 1'b0;
        run_sw = 1'b0;
        step_btn = 1'b0;
        w_sw = 1'b0;
        z_a = 1'b0;
        z_b = 1'b0;
        onehot_state = 5'b00001;
        exp_q.delete();
        cycles(3);
        reset = 1'b1;
        cycles(3);
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_pending: got %0d steps outstanding want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        int got;
        reset = 1'b0;
        run_sw = 1'b0;
        step_btn = 1'b0;
        w_sw = 1'b0;
        z_a = 1'b0;
        z_b = 1'b0;
        onehot_state = 5'b00001;
        cycles(3);
        checks++;
        if ({w_out, step_en, busy, mismatch, illegal_onehot, step_count} !== 13'd0) begin
            fails++;
            $display("FAIL reset_state: got %b want 0", {w_out, step_en, busy, mismatch, illegal_onehot, step_count});
        end
        reset = 1'b1;
        cycles(3);
        run_sw = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(seq[i]);
        count_pulses(5, 100, 4, got);
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_pre_busy: got %b want 1", busy);
        end
        #2;
        reset = 1'b0;
        run_sw = 1'b0;
        #1;
        checks++;
        if ({w_out, step_en, busy, mismatch, illegal_onehot, step_count} !== 13'd0) begin
            fails++;
            $display("FAIL reset_async: got %b want 0", {w_out, step_en, busy, mismatch, illegal_onehot, step_count});
        end
        check_queue_empty("reset");
        cycles(3);
        reset = 1'b1;
        cycles(15);
        checks++;
        if (step_count !== 8'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: got count=%0d busy=%b want count=0 busy=0", step_count, busy);
        end
    endtask

    task automatic test_manual;
        int got;
        do_reset();
        w_sw = 1'b1;
        exp_q.push_back(1'b1);
        for (int i = 0; i < 5; i++) begin
            step_btn = ~step_btn;
            cycles(2);
        end
        count_pulses(1, 60, 0, got);
        cycles(2);
        checks++;
        if (step_count !== 8'd1) begin
            fails++;
            $display("FAIL manual_count1: got %0d want 1", step_count);
        end
        cycles(10);
        step_btn = 1'b0;
        cycles(25);
        checks++;
        if (step_count !== 8'd1) begin
            fails++;
            $display("FAIL manual_release: got %0d want 1", step_count);
        end
        w_sw = 1'b0;
        exp_q.push_back(1'b0);
        step_btn = 1'b1;
        count_pulses(1, 60, 0, got);
        cycles(2);
        checks++;
        if (step_count !== 8'd2) begin
            fails++;
            $display("FAIL manual_count2: got %0d want 2", step_count);
        end
        step_btn = 1'b0;
        cycles(25);
        check_queue_empty("manual");
    endtask

    task automatic test_autorun;
        int got;
        do_reset();
        run_sw = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(seq[i]);
        count_pulses(8, 100, 4, got);
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL autorun_busy_mid: got %b want 1", busy);
        end
        count_pulses(8, 100, 4, got);
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL autorun_busy_end: got %b want 0", busy);
        end
        cycles(10);
        checks++;
        if (step_count !== 8'd16) begin
            fails++;
            $display("FAIL autorun_count: got %0d want 16", step_count);
        end
        check_queue_empty("autorun");
        run_sw = 1'b0;
        cycles(5);
    endtask

    task automatic test_abort;
        int got;
        do_reset();
        run_sw = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(seq[i]);
        count_pulses(5, 100, 4, got);
        run_sw = 1'b0;
        cycles(20);
        checks++;
        if (step_count !== 8'd5 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_stop: got count=%0d busy=%b want count=5 busy=0", step_count, busy);
        end
        run_sw = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(seq[i]);
        count_pulses(16, 200, 4, got);
        cycles(3);
        checks++;
        if (step_count !== 8'd21) begin
            fails++;
            $display("FAIL abort_restart_count: got %0d want 21", step_count);
        end
        run_sw = 1'b0;
        cycles(5);
        check_queue_empty("abort");
    endtask

    task automatic test_illegal;
        int got;
        do_reset();
        onehot_state = 5'b00000;
        cycles(5);
        checks++;
        if (illegal_onehot !== 1'b0) begin
            fails++;
            $display("FAIL illegal_noncheck: got %b want 0", illegal_onehot);
        end
        onehot_state = 5'b00001;
        w_sw = 1'b1;
        exp_q.push_back(1'b1);
        step_btn = 1'b1;
        count_pulses(1, 60, 0, got);
        onehot_state = 5'b00110;
        @(negedge clk);
        checks++;
        if (illegal_onehot !== 1'b0) begin
            fails++;
            $display("FAIL illegal_before_strobe: got %b want 0", illegal_onehot);
        end
        @(negedge clk);
        checks++;
        if (illegal_onehot !== 1'b1) begin
            fails++;
            $display("FAIL illegal_set: got %b want 1", illegal_onehot);
        end
        onehot_state = 5'b00001;
        step_btn = 1'b0;
        cycles(25);
`ifdef FSM_STEP_HALT_ON_ERR_EN
        step_btn = 1'b1;
        cycles(40);
        checks++;
        if (step_count !== 8'd1) begin
            fails++;
            $display("FAIL illegal_halt_count: got %0d want 1", step_count);
        end
`else
        exp_q.push_back(1'b1);
        step_btn = 1'b1;
        count_pulses(1, 60, 0, got);
        cycles(3);
        checks++;
        if (step_count !== 8'd2) begin
            fails++;
            $display("FAIL illegal_continue_count: got %0d want 2", step_count);
        end
`endif
        checks++;
        if (illegal_onehot !== 1'b1 || mismatch !== 1'b0) begin
            fails++;
            $display("FAIL illegal_sticky: got illegal=%b mismatch=%b want 1 0", illegal_onehot, mismatch);
        end
        step_btn = 1'b0;
        cycles(25);
        check_queue_empty("illegal");
    endtask

    task automatic test_mismatch;
        int got;
        do_reset();
        run_sw = 1'b1;
`ifdef FSM_STEP_HALT_ON_ERR_EN
        for (int i = 0; i < 3; i++) exp_q.push_back(seq[i]);
`else
        for (int i = 0; i < 16; i++) exp_q.push_back(seq[i]);
`endif
        count_pulses(3, 100, 4, got);
        z_b = 1'b1;
        @(negedge clk);
        checks++;
        if (mismatch !== 1'b0) begin
            fails++;
            $display("FAIL mismatch_before_strobe: got %b want 0", mismatch);
        end
        @(negedge clk);
        checks++;
        if (mismatch !== 1'b1) begin
            fails++;
            $display("FAIL mismatch_set: got %b want 1", mismatch);
        end
        z_b = 1'b0;
`ifdef FSM_STEP_HALT_ON_ERR_EN
        cycles(40);
        checks++;
        if (step_count !== 8'd3 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mismatch_halt: got count=%0d busy=%b want count=3 busy=0", step_count, busy);
        end
`else
        count_pulses(13, 200, 4, got);
        cycles(3);
        checks++;
        if (step_count !== 8'd16) begin
            fails++;
            $display("FAIL mismatch_continue_count: got %0d want 16", step_count);
        end
`endif
        checks++;
        if (mismatch !== 1'b1 || illegal_onehot !== 1'b0) begin
            fails++;
            $display("FAIL mismatch_sticky: got mismatch=%b illegal=%b want 1 0", mismatch, illegal_onehot);
        end
        run_sw = 1'b0;
        cycles(5);
        check_queue_empty("mismatch");
    endtask

    initial begin
        test_reset();
        test_manual();
        test_autorun();
        test_abort();
        test_illegal();
        test_mismatch();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
